// File: rtl/barrel_shift_sched_pkg.sv
// ============================================================================
// Module      : barrel_shift_sched_pkg
// Description : Shared state encoding and shift-sequencing constants for the
//               barrel_shift_sched scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_shift_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_STEP = 3;
    localparam int AMT_W    = 3;

    // Largest pass the 2-bit shift select can do, clipped to what remains.
    function automatic logic [1:0] step_of(input logic [AMT_W-1:0] rem);
        return (rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shl4.sv
// ============================================================================
// Module      : barrel_shl4
// Description : 4-bit logical left barrel shifter, two 2:1 mux stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shl4
    import barrel_shift_sched_pkg::*;
(
    input  logic [3:0] in,
    input  logic [1:0] s_n,
    output logic [3:0] out
);

    logic [3:0] w_stage1;

    assign w_stage1 = s_n[0] ? {in[2:0], 1'b0} : in;
    assign out      = s_n[1] ? {w_stage1[1:0], 2'b00} : w_stage1;

endmodule

`default_nettype wire

// File: rtl/barrel_shift_sched.sv
// ============================================================================
// Module      : barrel_shift_sched
// Description : Round-robin scheduler sharing one barrel_shl4 between two
//               requesters; long shifts run as repeated passes of <= 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_sched
    import barrel_shift_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
);

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_acc, w_acc_nxt;
    logic [AMT_W-1:0] r_rem, w_rem_nxt;
    logic             r_id, w_id_nxt;
    logic             r_last_grant, w_last_grant_nxt;

    logic             w_grant0, w_grant1;
    logic [1:0]       w_step;
    logic [AMT_W-1:0] w_rem_sub;
    logic [W-1:0]     w_shifted;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = r_last_grant;
            w_grant1 = !r_last_grant;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    assign req0_ready = (r_state == ST_IDLE) && w_grant0;
    assign req1_ready = (r_state == ST_IDLE) && w_grant1;

    assign w_step    = step_of(r_rem);
    assign w_rem_sub = r_rem - AMT_W'(w_step);

    barrel_shl4 u_shl (
        .in  (r_acc),
        .s_n (w_step),
        .out (w_shifted)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_rem_nxt        = r_rem;
        w_id_nxt         = r_id;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_grant0) begin
                    w_acc_nxt        = req0_data;
                    w_rem_nxt        = req0_amt;
                    w_id_nxt         = 1'b0;
                    w_last_grant_nxt = 1'b0;
                    w_state_nxt      = ST_EXEC;
                end else if (w_grant1) begin
                    w_acc_nxt        = req1_data;
                    w_rem_nxt        = req1_amt;
                    w_id_nxt         = 1'b1;
                    w_last_grant_nxt = 1'b1;
                    w_state_nxt      = ST_EXEC;
                end
            end
            // A zero amount still spends one pass here with a zero step.
            ST_EXEC: begin
                w_acc_nxt = w_shifted;
                w_rem_nxt = w_rem_sub;
                if (w_rem_sub == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_rem        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_rem        <= w_rem_nxt;
            r_id         <= w_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign out_data  = out_valid ? r_acc : '0;
    assign out_id    = out_valid && r_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
